// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int XLEN = 32;
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    FETCH    = 3'd1,
    WAIT_EXE = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } pc_state_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] & PC_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_retire_counter.sv
// 32-bit wrapping retired-instruction counter with increment enable.
module retire_counter
  import pc_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic [XLEN-1:0] count
);

  // counter register, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, issues fetches, drives the next-PC mux select.
// Optional retire counter enabled by defining PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemAck,
  output logic            instrValid,
  input  logic            exeDone,
  input  logic            branchTaken,
  input  logic            halt,
  output logic            pcSrc,
  input  logic [XLEN-1:0] pcNext,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            running,
  output logic            misalignedTrap,
  output logic [XLEN-1:0] instret
);

  pc_state_t       state_r;
  pc_state_t       state_s;
  logic [XLEN-1:0] pc_r;
  logic            trap_r;
  logic            commit_s;
  logic            set_trap_s;

  // halt wins over misalignment; only a clean completion commits
  assign commit_s   = (state_r == WAIT_EXE) && exeDone && !halt && !is_misaligned(pcNext);
  assign set_trap_s = (state_r == WAIT_EXE) && exeDone && !halt && is_misaligned(pcNext);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_s    = state_r;
    imemReq    = 1'b0;
    instrValid = 1'b0;
    running    = 1'b0;
    pcSrc      = 1'b0;
    case (state_r)
      BOOT: begin
        running = 1'b1;
        state_s = FETCH;
      end
      FETCH: begin
        running = 1'b1;
        imemReq = 1'b1;
        if (imemAck) begin
          state_s = WAIT_EXE;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT_EXE: begin
        running    = 1'b1;
        instrValid = 1'b1;
        pcSrc      = branchTaken & exeDone;
        if (!exeDone) begin
          state_s = WAIT_EXE;
        end else if (halt) begin
          state_s = HALTED;
        end else if (is_misaligned(pcNext)) begin
          state_s = FAULT;
        end else begin
          state_s = FETCH;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      FAULT: begin
        state_s = FAULT;
      end
      default: begin
        state_s = FAULT;
      end
    endcase
  end

  // PC register and sticky misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r   <= RESET_VECTOR;
      trap_r <= 1'b0;
    end else begin
      if (commit_s) begin
        pc_r <= pcNext;
      end else begin
        pc_r <= pc_r;
      end
      trap_r <= trap_r | set_trap_s;
    end
  end

  assign pc             = pc_r;
  assign imemAddr       = pc_r;
  assign pcPlus4        = pc_r + 32'd4;
  assign misalignedTrap = trap_r;

`ifdef PC_SEQ_RETIRE_CNT_EN
  retire_counter u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .en    (commit_s),
    .count (instret)
  );
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic        instrValid;
  logic        exeDone;
  logic        branchTaken;
  logic        halt;
  logic        pcSrc;
  logic [31:0] pcNext;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        running;
  logic        misalignedTrap;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemAck        (imemAck),
    .instrValid     (instrValid),
    .exeDone        (exeDone),
    .branchTaken    (branchTaken),
    .halt           (halt),
    .pcSrc          (pcSrc),
    .pcNext         (pcNext),
    .pc             (pc),
    .pcPlus4        (pcPlus4),
    .running        (running),
    .misalignedTrap (misalignedTrap),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instret(input logic [31:0] n);
`ifdef PC_SEQ_RETIRE_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT in FETCH at pc 0, just after the active edge.
  task automatic do_reset();
    reset = 1'b1;
    imemAck = 1'b0; exeDone = 1'b0; branchTaken = 1'b0; halt = 1'b0; pcNext = 32'd0;
    #1;
    check("rst_req",     {31'd0, imemReq}, 32'd0);
    check("rst_ivalid",  {31'd0, instrValid}, 32'd0);
    check("rst_pc",      pc, 32'd0);
    check("rst_trap",    {31'd0, misalignedTrap}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_running", {31'd0, running}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_req", {31'd0, imemReq}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // In FETCH: check the request, acknowledge in the first cycle.
  task automatic fetch_ack(input logic [31:0] addr);
    check("fetch_req",    {31'd0, imemReq}, 32'd1);
    check("fetch_addr",   imemAddr, addr);
    check("fetch_ivalid", {31'd0, instrValid}, 32'd0);
    imemAck = 1'b1;
    @(posedge clk);
    #1;
    imemAck = 1'b0;
    check("wait_ivalid", {31'd0, instrValid}, 32'd1);
    check("wait_req",    {31'd0, imemReq}, 32'd0);
  endtask

  // In WAIT_EXE: complete the instruction with the given mux output.
  task automatic execute(input logic taken, input logic [31:0] nxt, input logic hlt);
    branchTaken = taken; halt = hlt; pcNext = nxt; exeDone = 1'b1;
    #1;
    check("pcsrc", {31'd0, pcSrc}, {31'd0, taken});
    @(posedge clk);
    #1;
    exeDone = 1'b0; branchTaken = 1'b0; halt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imemAck = 1'b0; exeDone = 1'b0; branchTaken = 1'b0;
    halt = 1'b0; pcNext = 32'd0;
    #12;
    do_reset();

    // four sequential not-taken instructions, 2 cycles each
    for (int i = 0; i < 4; i++) begin
      fetch_ack(32'(4 * i));
      execute(1'b0, 32'(4 * i + 4), 1'b0);
    end
    check("seq_pc",      pc, 32'd16);
    check("seq_instret", instret, exp_instret(32'd4));

    // stalled fetch with a stray exeDone that must be ignored
    exeDone = 1'b1; branchTaken = 1'b1; pcNext = 32'h40;
    for (int i = 0; i < 5; i++) begin
      check("stall_req",    {31'd0, imemReq}, 32'd1);
      check("stall_addr",   imemAddr, 32'd16);
      check("stall_ivalid", {31'd0, instrValid}, 32'd0);
      check("stall_pcsrc",  {31'd0, pcSrc}, 32'd0);
      @(posedge clk);
      #1;
    end
    exeDone = 1'b0; branchTaken = 1'b0;
    fetch_ack(32'd16);

    // taken branch at pc 8
    do_reset();
    fetch_ack(32'd0);
    execute(1'b0, 32'd4, 1'b0);
    fetch_ack(32'd4);
    execute(1'b0, 32'd8, 1'b0);
    fetch_ack(32'd8);
    execute(1'b1, 32'h100, 1'b0);
    check("br_instret", instret, exp_instret(32'd3));
    fetch_ack(32'h100);

    // misaligned target
    execute(1'b0, 32'h102, 1'b0);
    check("mis_trap",    {31'd0, misalignedTrap}, 32'd1);
    check("mis_pc",      pc, 32'h100);
    check("mis_running", {31'd0, running}, 32'd0);
    check("mis_req",     {31'd0, imemReq}, 32'd0);
    check("mis_ivalid",  {31'd0, instrValid}, 32'd0);
    check("mis_instret", instret, exp_instret(32'd3));
    imemAck = 1'b1; exeDone = 1'b1; branchTaken = 1'b1; pcNext = 32'd4;
    #1;
    check("fault_pcsrc", {31'd0, pcSrc}, 32'd0);
    @(posedge clk);
    #1;
    check("fault_stays", {31'd0, misalignedTrap, running}, 32'd2);
    check("fault_pc",    pc, 32'h100);
    imemAck = 1'b0; exeDone = 1'b0; branchTaken = 1'b0;

    // halt wins over misalignment
    do_reset();
    fetch_ack(32'd0);
    execute(1'b0, 32'd4, 1'b0);
    fetch_ack(32'd4);
    execute(1'b0, 32'h102, 1'b1);
    check("halt_trap",    {31'd0, misalignedTrap}, 32'd0);
    check("halt_running", {31'd0, running}, 32'd0);
    check("halt_pc",      pc, 32'd4);
    check("halt_instret", instret, exp_instret(32'd1));
    check("halt_req",     {31'd0, imemReq}, 32'd0);

    // reset asserted mid-fetch
    do_reset();
    fetch_ack(32'd0);
    execute(1'b1, 32'h100, 1'b0);
    check("mid_req_pre", {31'd0, imemReq}, 32'd1);
    imemAck = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("mid_req",    {31'd0, imemReq}, 32'd0);
    check("mid_pc",     pc, 32'd0);
    check("mid_ivalid", {31'd0, instrValid}, 32'd0);
    do_reset();

    // pc wrap from 0xFFFF_FFFC
    fetch_ack(32'd0);
    execute(1'b1, 32'hFFFF_FFFC, 1'b0);
    check("wrap_plus4", pcPlus4, 32'd0);
    fetch_ack(32'hFFFF_FFFC);
    execute(1'b0, 32'd0, 1'b0);
    check("wrap_pc",      pc, 32'd0);
    check("wrap_instret", instret, exp_instret(32'd2));
    check("wrap_req",     {31'd0, imemReq}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
